// File: rtl/cordic_pkg.sv
// cordic_pkg
//   Shared definitions for the CORDIC controllers: angle format, the pi/2
//   clamp limits, the arctangent table and the controller state encoding.
//   Angles are signed two's complement Q1.22 radians in 24 bits.
package cordic_pkg;

  localparam int ANGLE_W    = 24;
  localparam int ANGLE_FRAC = 22;

  // +pi/2 and -pi/2 in Q1.22; inputs beyond these are clamped.
  localparam logic [ANGLE_W-1:0] HALF_PI     = 24'h6487ED;
  localparam logic [ANGLE_W-1:0] NEG_HALF_PI = 24'h9B7813;

  // atan[i] = round(atan(2^-i) * 2^ANGLE_FRAC)
  localparam logic [ANGLE_W-1:0] ATAN_TABLE [0:15] = '{
    24'h3243F7, 24'h1DAC67, 24'h0FADBB, 24'h07F56F,
    24'h03FEAB, 24'h01FFD5, 24'h00FFFB, 24'h007FFF,
    24'h004000, 24'h002000, 24'h001000, 24'h000800,
    24'h000400, 24'h000200, 24'h000100, 24'h000080
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } cordic_state_t;

endpackage

// File: rtl/cordic_atan_rom.sv
// cordic_atan_rom
//   Combinational arctangent lookup, shared by rotation and vectoring
//   controllers.
//   Ports:
//     idx   in   4   iteration index
//     atan  out  24  round(atan(2^-idx) * 2^22), Q1.22
module cordic_atan_rom
  import cordic_pkg::*;
(
  input  logic [3:0]         idx,
  output logic [ANGLE_W-1:0] atan
);

  assign atan = ATAN_TABLE[idx];

endmodule

// File: rtl/cordic_rotation_controller.sv
// cordic_rotation_controller
//   Rotation-mode sequencer for the CORDIC add/sub datapath. Accepts a target
//   angle, clamps it to +/-pi/2, then runs N_ITER micro-rotations of two
//   datapath cycles each (X-phase, Y-phase) while accumulating the residual
//   angle Z. Reports the residual with a one-cycle done pulse.
//   Ports:
//     iClk     in   1   clock
//     iRst_n   in   1   synchronous active-low reset
//     iStart   in   1   operation request, sampled only while oReady=1
//     iAngle   in   24  target angle, Q1.22
//     oReady   out  1   idle, can accept a request
//     oBusy    out  1   running micro-rotations
//     oStart   out  1   datapath step strobe
//     oShift   out  4   current iteration index
//     oSignZ   out  1   rotation direction (Z sign)
//     oDone    out  1   completion pulse
//     oZ       out  24  residual angle, held until next completion
//     oSat     out  1   input angle was clamped, held until next accept
module cordic_rotation_controller
  import cordic_pkg::*;
#(
  parameter int unsigned N_ITER = 16
) (
  input  logic                iClk,
  input  logic                iRst_n,
  input  logic                iStart,
  input  logic [ANGLE_W-1:0]  iAngle,
  output logic                oReady,
  output logic                oBusy,
  output logic                oStart,
  output logic [3:0]          oShift,
  output logic                oSignZ,
  output logic                oDone,
  output logic [ANGLE_W-1:0]  oZ,
  output logic                oSat
);

  cordic_state_t       state;
  logic [ANGLE_W-1:0]  z;
  logic [ANGLE_W-1:0]  z_res;
  logic [3:0]          iter;
  logic                ph;
  logic                sat;

  logic [ANGLE_W-1:0]  atan;
  logic [ANGLE_W-1:0]  z_step;
  logic [ANGLE_W-1:0]  z_init;
  logic                over;
  logic                under;
  logic                last_iter;

  cordic_atan_rom u_atan_rom (
    .idx  (iter),
    .atan (atan)
  );

  // Input clamp to +/-pi/2.
  always_comb begin
    over   = $signed(iAngle) > $signed(HALF_PI);
    under  = $signed(iAngle) < $signed(NEG_HALF_PI);
    z_init = iAngle;
    if (over) begin
      z_init = HALF_PI;
    end else if (under) begin
      z_init = NEG_HALF_PI;
    end
  end

  // Drive Z toward zero: subtract when non-negative, add when negative.
  always_comb begin
    z_step    = z[ANGLE_W-1] ? (z + atan) : (z - atan);
    last_iter = (iter == 4'(N_ITER - 1));
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state <= ST_IDLE;
      z     <= '0;
      z_res <= '0;
      iter  <= '0;
      ph    <= 1'b0;
      sat   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (iStart) begin
            state <= ST_RUN;
            z     <= z_init;
            iter  <= '0;
            ph    <= 1'b0;
            sat   <= over | under;
          end
        end
        ST_RUN: begin
          ph <= ~ph;
          // Z changes only at the end of the Y-phase so the sign seen by the
          // datapath is stable across both phases of an iteration.
          if (ph) begin
            z    <= z_step;
            iter <= iter + 4'd1;
            if (last_iter) begin
              state <= ST_DONE;
              z_res <= z_step;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Moore outputs decoded from registered state only.
  always_comb begin
    oReady = (state == ST_IDLE);
    oBusy  = (state == ST_RUN);
    oStart = (state == ST_RUN);
    oShift = (state == ST_RUN) ? iter : '0;
    oSignZ = (state == ST_RUN) & z[ANGLE_W-1];
    oDone  = (state == ST_DONE);
    oZ     = z_res;
    oSat   = sat;
  end

endmodule

// File: tb/tb_cordic_rotation_controller.sv
// tb_cordic_rotation_controller
//   Directed-vector bench for cordic_rotation_controller with N_ITER=16.
//   Cycle T+k denotes the k-th clock period after the accept edge; outputs
//   are sampled on the falling edge inside that period.
module tb_cordic_rotation_controller;

  logic        iClk = 1'b0;
  logic        iRst_n = 1'b0;
  logic        iStart = 1'b0;
  logic [23:0] iAngle = '0;
  logic        oReady;
  logic        oBusy;
  logic        oStart;
  logic [3:0]  oShift;
  logic        oSignZ;
  logic        oDone;
  logic [23:0] oZ;
  logic        oSat;

  int vectors = 0;
  int miscompares = 0;

  always #5 iClk = ~iClk;

  cordic_rotation_controller #(.N_ITER(16)) dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iStart (iStart),
    .iAngle (iAngle),
    .oReady (oReady),
    .oBusy  (oBusy),
    .oStart (oStart),
    .oShift (oShift),
    .oSignZ (oSignZ),
    .oDone  (oDone),
    .oZ     (oZ),
    .oSat   (oSat)
  );

  // Hand-computed round(atan(2^-i) * 2^22).
  function automatic logic [23:0] ref_atan(input int i);
    case (i)
      0:  return 24'h3243F7;
      1:  return 24'h1DAC67;
      2:  return 24'h0FADBB;
      3:  return 24'h07F56F;
      4:  return 24'h03FEAB;
      5:  return 24'h01FFD5;
      6:  return 24'h00FFFB;
      7:  return 24'h007FFF;
      8:  return 24'h004000;
      9:  return 24'h002000;
      10: return 24'h001000;
      11: return 24'h000800;
      12: return 24'h000400;
      13: return 24'h000200;
      14: return 24'h000100;
      default: return 24'h000080;
    endcase
  endfunction

  task automatic test_reset();
    iRst_n = 1'b0;
    iStart = 1'b1;
    iAngle = 24'h123456;
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    vectors++;
    if ({oReady, oBusy, oStart, oDone, oSignZ, oSat} !== 6'b100000) begin
      miscompares++;
      $display("FAIL reset_flags: got rdy/busy/start/done/sign/sat=%b want 100000",
               {oReady, oBusy, oStart, oDone, oSignZ, oSat});
    end
    vectors++;
    if (oShift !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_shift: got %0d want 0", oShift);
    end
    vectors++;
    if (oZ !== 24'h000000) begin
      miscompares++;
      $display("FAIL reset_z: got %h want 000000", oZ);
    end
    iStart = 1'b0;
    iRst_n = 1'b1;
    @(negedge iClk);
    vectors++;
    if ({oReady, oBusy} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_release_idle: got rdy/busy=%b want 10", {oReady, oBusy});
    end
  endtask

  task automatic test_rotation(input string name, input logic [23:0] angle,
                               input logic hand_sat, input int n_hand,
                               input logic [3:0] hand_signs, input bit check_small);
    logic [23:0] z;
    logic [15:0] signs;
    int av;
    int it;
    int zr;
    int hp;
    hp = 32'h0064_87ED;
    av = int'($signed(angle));
    if (av > hp) z = 24'h6487ED;
    else if (av < -hp) z = 24'h9B7813;
    else z = angle;
    for (int i = 0; i < 16; i++) begin
      signs[i] = z[23];
      z = z[23] ? (z + ref_atan(i)) : (z - ref_atan(i));
    end

    @(negedge iClk);
    vectors++;
    if (oReady !== 1'b1) begin
      miscompares++;
      $display("FAIL %s ready_before_accept: got %b want 1", name, oReady);
    end
    iStart = 1'b1;
    iAngle = angle;
    @(posedge iClk);
    #1;
    iStart = 1'b0;
    iAngle = ~angle;
    for (int k = 1; k <= 35; k++) begin
      @(negedge iClk);
      if (k <= 32) begin
        it = (k - 1) / 2;
        vectors++;
        if ({oStart, oBusy, oReady, oDone} !== 4'b1100) begin
          miscompares++;
          $display("FAIL %s run_flags T+%0d: got start/busy/rdy/done=%b want 1100",
                   name, k, {oStart, oBusy, oReady, oDone});
        end
        vectors++;
        if (oShift !== it[3:0]) begin
          miscompares++;
          $display("FAIL %s shift T+%0d: got %0d want %0d", name, k, oShift, it);
        end
        vectors++;
        if (oSignZ !== signs[it]) begin
          miscompares++;
          $display("FAIL %s signz T+%0d: got %b want %b", name, k, oSignZ, signs[it]);
        end
        if (it < n_hand) begin
          vectors++;
          if (oSignZ !== hand_signs[it]) begin
            miscompares++;
            $display("FAIL %s hand_signz iter%0d: got %b want %b", name, it, oSignZ,
                     hand_signs[it]);
          end
        end
      end else if (k == 33) begin
        vectors++;
        if ({oStart, oBusy, oReady, oDone} !== 4'b0001) begin
          miscompares++;
          $display("FAIL %s done_flags: got start/busy/rdy/done=%b want 0001",
                   name, {oStart, oBusy, oReady, oDone});
        end
        vectors++;
        if (oZ !== z) begin
          miscompares++;
          $display("FAIL %s residual: got %h want %h", name, oZ, z);
        end
        vectors++;
        if (oSat !== hand_sat) begin
          miscompares++;
          $display("FAIL %s sat: got %b want %b", name, oSat, hand_sat);
        end
        if (check_small) begin
          zr = int'($signed(oZ));
          vectors++;
          if (zr >= 128 || zr <= -128) begin
            miscompares++;
            $display("FAIL %s residual_small: got %0d want |z|<128", name, zr);
          end
        end
      end else begin
        vectors++;
        if ({oStart, oBusy, oReady, oDone} !== 4'b0010) begin
          miscompares++;
          $display("FAIL %s idle_flags T+%0d: got start/busy/rdy/done=%b want 0010",
                   name, k, {oStart, oBusy, oReady, oDone});
        end
        vectors++;
        if ({oZ, oSat} !== {z, hand_sat}) begin
          miscompares++;
          $display("FAIL %s held T+%0d: got z=%h sat=%b want z=%h sat=%b",
                   name, k, oZ, oSat, z, hand_sat);
        end
      end
    end
  endtask

  task automatic test_ignore_start();
    int starts;
    int dones;
    starts = 0;
    dones = 0;
    @(negedge iClk);
    iStart = 1'b1;
    iAngle = 24'h0A0000;
    @(posedge iClk);
    #1;
    iStart = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge iClk);
      starts += int'(oStart);
      dones += int'(oDone);
      vectors++;
      if (oStart !== (k <= 32)) begin
        miscompares++;
        $display("FAIL ignore oStart T+%0d: got %b want %b", k, oStart, (k <= 32));
      end
      vectors++;
      if (oReady !== (k >= 34)) begin
        miscompares++;
        $display("FAIL ignore oReady T+%0d: got %b want %b", k, oReady, (k >= 34));
      end
      iStart = (k == 5 || k == 20);
    end
    vectors++;
    if (starts !== 32) begin
      miscompares++;
      $display("FAIL ignore start_count: got %0d want 32", starts);
    end
    vectors++;
    if (dones !== 1) begin
      miscompares++;
      $display("FAIL ignore done_count: got %0d want 1", dones);
    end
  endtask

  task automatic test_reset_mid_run();
    int exp_shift;
    @(negedge iClk);
    iStart = 1'b1;
    iAngle = 24'h200000;
    @(posedge iClk);
    #1;
    iStart = 1'b0;
    for (int k = 1; k <= 46; k++) begin
      @(negedge iClk);
      if (k <= 12) begin
        vectors++;
        if (oDone !== 1'b0) begin
          miscompares++;
          $display("FAIL rst_mid no_done T+%0d: got %b want 0", k, oDone);
        end
      end
      if (k <= 10) begin
        vectors++;
        if (oStart !== 1'b1) begin
          miscompares++;
          $display("FAIL rst_mid pre_start T+%0d: got %b want 1", k, oStart);
        end
      end
      if (k == 11 || k == 12) begin
        vectors++;
        if ({oReady, oBusy, oStart, oShift, oSignZ, oSat, oZ} !== {3'b100, 4'd0, 2'b00, 24'h0}) begin
          miscompares++;
          $display("FAIL rst_mid reset_vals T+%0d: got rdy=%b busy=%b start=%b shift=%0d sign=%b sat=%b z=%h want 1 0 0 0 0 0 000000",
                   k, oReady, oBusy, oStart, oShift, oSignZ, oSat, oZ);
        end
      end
      if (k >= 13 && k <= 44) begin
        exp_shift = (k - 13) / 2;
        vectors++;
        if ({oStart, oShift} !== {1'b1, exp_shift[3:0]}) begin
          miscompares++;
          $display("FAIL rst_mid rerun T+%0d: got start=%b shift=%0d want 1 %0d",
                   k, oStart, oShift, exp_shift);
        end
      end
      if (k == 45) begin
        vectors++;
        if ({oStart, oDone} !== 2'b01) begin
          miscompares++;
          $display("FAIL rst_mid rerun_done: got start/done=%b want 01", {oStart, oDone});
        end
      end
      if (k == 10) iRst_n = 1'b0;
      if (k == 11) iRst_n = 1'b1;
      if (k == 12) begin
        iStart = 1'b1;
        iAngle = 24'h050000;
      end
      if (k == 13) iStart = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic exp_start;
    logic exp_done;
    @(negedge iClk);
    iStart = 1'b1;
    iAngle = 24'h100000;
    @(posedge iClk);
    #1;
    iAngle = 24'hF00000;
    for (int k = 1; k <= 68; k++) begin
      @(negedge iClk);
      exp_start = (k <= 32) || (k >= 35 && k <= 66);
      exp_done = (k == 33) || (k == 67);
      vectors++;
      if ({oStart, oDone} !== {exp_start, exp_done}) begin
        miscompares++;
        $display("FAIL b2b start/done T+%0d: got %b%b want %b%b",
                 k, oStart, oDone, exp_start, exp_done);
      end
      if (k == 34 || k == 68) begin
        vectors++;
        if (oReady !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b ready T+%0d: got %b want 1", k, oReady);
        end
      end
      if (k == 1 || k == 2) begin
        vectors++;
        if (oSignZ !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b first_sign T+%0d: got %b want 0", k, oSignZ);
        end
      end
      if (k == 35 || k == 36) begin
        vectors++;
        if (oSignZ !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b second_sign T+%0d: got %b want 1", k, oSignZ);
        end
      end
      if (k == 67) iStart = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rotation("zero",     24'h000000, 1'b0, 2, 4'b0010, 1'b1);
    test_rotation("quarter",  24'h3243F7, 1'b0, 2, 4'b0000, 1'b1);
    test_rotation("sat_pos",  24'h7FFFFF, 1'b1, 3, 4'b0000, 1'b1);
    test_rotation("sat_neg",  24'h800000, 1'b1, 1, 4'b0001, 1'b1);
    test_rotation("edge_pos", 24'h6487ED, 1'b0, 1, 4'b0000, 1'b0);
    test_rotation("over_pos", 24'h6487EE, 1'b1, 1, 4'b0000, 1'b0);
    test_rotation("edge_neg", 24'h9B7813, 1'b0, 1, 4'b0001, 1'b0);
    test_rotation("over_neg", 24'h9B7812, 1'b1, 1, 4'b0001, 1'b0);
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
